// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divider configuration sequencer.
package clk_div_ctrl_pkg;

    // Sequencer states: IDLE holds the divider in reset, RUN lets it count,
    // DRAIN waits for the current period to finish, LOAD applies a new ratio.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        LOAD  = 2'd3
    } ctrl_state_e;

    // Smallest divide ratio the divider can produce without a degenerate clock.
    localparam int MIN_DIV = 2;

    // Width of the optional reconfiguration statistics counter.
    localparam int STATS_WIDTH = 16;

    // True for the states in which the divider is held in reset.
    function automatic logic state_is_quiet(input ctrl_state_e s);
        return (s == IDLE) || (s == LOAD);
    endfunction

endpackage

// File: rtl/clk_div_period_tracker.sv
// Shadow period counter mirroring the divider's positive-edge counter.
// 'clear' is the divider reset value that will be registered at the coming
// edge, so the shadow count reads 0 in every cycle the divider is held in
// reset, and restarts from 0 in the first running cycle.
module clk_div_period_tracker
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] div_num,
    output logic             period_tick
);

    logic [WIDTH-1:0] cnt_reg;
    logic             active_reg;
    logic             at_last;

    // Last count value of a period for the ratio currently driven.
    assign at_last = (cnt_reg == (div_num - WIDTH'(1)));

    // Only a running divider can end a period.
    assign period_tick = active_reg && at_last;

    // Count through the period while running; hold at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            active_reg <= !clear;
            if (clear || !active_reg || at_last) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Configuration sequencer for the shared N-way clock divider.
// Accepts ratio updates over valid/ready, rejects ratios below MIN_DIV, and
// applies accepted ratios only on a period boundary by pulsing div_reset for
// HOLD_CYCLES cycles while loading the new div_num.
// Optional build macro CLK_DIV_CTRL_STATS_EN adds the reconfig_count output,
// counting LOAD entries that actually change div_num (saturating).
module clk_div_cfg_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50000000,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] div_num,
    output logic             div_reset,
    output logic             period_tick,
    output logic             busy
`ifdef CLK_DIV_CTRL_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] reconfig_count
`endif
);

    localparam int               HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_VAL     = WIDTH'(MIN_DIV);

    ctrl_state_e       state_reg;
    logic [WIDTH-1:0]  pending_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;

    logic              xfer;
    logic              cfg_bad;
    logic              hold_done;
    logic              load_enter;
    logic [WIDTH-1:0]  load_val;
    logic              clear_next;

    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_div < MIN_VAL);
    assign hold_done = (hold_cnt_reg == HOLD_LAST);

    // Decide whether LOAD is entered at this edge, which ratio it applies, and
    // whether the divider will be held in reset after the edge.
    always_comb begin
        load_enter = 1'b0;
        load_val   = pending_reg;
        clear_next = 1'b1;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    // A rejected ratio consumes the transfer and leaves IDLE as is.
                    load_enter = !cfg_bad;
                    load_val   = cfg_div;
                end else begin
                    // Restart with the ratio already in use.
                    load_enter = enable;
                    load_val   = div_num;
                end
            end
            RUN: begin
                clear_next = !enable;
            end
            DRAIN: begin
                // Dropping enable abandons the drain; otherwise wait for the boundary.
                load_enter = !enable || period_tick;
                clear_next = load_enter;
            end
            LOAD: begin
                clear_next = !(hold_done && enable);
            end
            default: begin
                clear_next = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with registered handshake and divider-control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            div_num      <= DEFAULT_VAL;
            div_reset    <= 1'b1;
            cfg_ready    <= 1'b0;
            cfg_err      <= 1'b0;
            busy         <= 1'b0;
            pending_reg  <= DEFAULT_VAL;
            hold_cnt_reg <= '0;
        end else begin
            cfg_err <= 1'b0;
            if (load_enter) begin
                state_reg    <= LOAD;
                pending_reg  <= load_val;
                div_num      <= load_val;
                hold_cnt_reg <= '0;
                div_reset    <= 1'b1;
                cfg_ready    <= 1'b0;
                busy         <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        div_reset <= 1'b1;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        // Only a rejected ratio reaches here with a transfer.
                        if (xfer) begin
                            cfg_err <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!enable) begin
                            // Enable wins over a simultaneous cfg offer.
                            state_reg <= IDLE;
                            div_reset <= 1'b1;
                            cfg_ready <= 1'b1;
                        end else if (xfer) begin
                            if (cfg_bad) begin
                                cfg_err <= 1'b1;
                            end else begin
                                state_reg   <= DRAIN;
                                pending_reg <= cfg_div;
                                cfg_ready   <= 1'b0;
                                busy        <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        // Leaves only through load_enter.
                        busy <= 1'b1;
                    end
                    LOAD: begin
                        if (hold_done) begin
                            state_reg <= enable ? RUN : IDLE;
                            div_reset <= !enable;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        div_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

    clk_div_period_tracker #(
        .WIDTH(WIDTH)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_next),
        .div_num    (div_num),
        .period_tick(period_tick)
    );

`ifdef CLK_DIV_CTRL_STATS_EN
    // Count LOAD entries that change the ratio; saturate instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reconfig_count <= '0;
        end else if (load_enter && (load_val != div_num) && (reconfig_count != '1)) begin
            reconfig_count <= reconfig_count + STATS_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model. Build with CLK_DIV_CTRL_STATS_EN to cover reconfig_count.
module tb_clk_div_cfg_ctrl;

    localparam int W    = 16;
    localparam int DEF  = 4;
    localparam int HOLD = 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_LOAD  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic [W-1:0] div_num;
    logic         div_reset;
    logic         period_tick;
    logic         busy;
`ifdef CLK_DIV_CTRL_STATS_EN
    logic [15:0]  reconfig_count;
`endif

    clk_div_cfg_ctrl #(
        .WIDTH      (W),
        .DEFAULT_DIV(DEF),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .div_num    (div_num),
        .div_reset  (div_reset),
        .period_tick(period_tick),
        .busy       (busy)
`ifdef CLK_DIV_CTRL_STATS_EN
        ,
        .reconfig_count(reconfig_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_div, m_pend, m_pos, m_left, m_stats;
    bit m_ready, m_err;

    task automatic m_enter_load(input int v);
        if (v != m_div && m_stats < 65535) m_stats++;
        m_div   = v;
        m_pend  = v;
        m_state = S_LOAD;
        m_left  = HOLD;
        m_pos   = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        bit xfer;
        if (reset) begin
            m_state = S_IDLE; m_div = DEF; m_pend = DEF; m_pos = 0;
            m_left = 0; m_ready = 1'b0; m_err = 1'b0; m_stats = 0;
        end else begin
            xfer  = cfg_valid && m_ready;
            m_err = 1'b0;
            case (m_state)
                S_IDLE: begin
                    if (xfer) begin
                        if (cfg_div < 2) begin
                            m_err = 1'b1;
                            $display("cfg %0d in IDLE: rejected", cfg_div);
                        end else begin
                            $display("cfg %0d in IDLE: accepted", cfg_div);
                            m_enter_load(int'(cfg_div));
                        end
                    end else if (enable) begin
                        m_enter_load(m_div);
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        if (xfer) $display("cfg %0d in RUN: ignored, enable low", cfg_div);
                        m_state = S_IDLE;
                        m_pos   = 0;
                    end else begin
                        m_pos = (m_pos + 1) % m_div;
                        if (xfer) begin
                            if (cfg_div < 2) begin
                                m_err = 1'b1;
                                $display("cfg %0d in RUN: rejected", cfg_div);
                            end else begin
                                $display("cfg %0d in RUN: accepted, draining", cfg_div);
                                m_pend  = int'(cfg_div);
                                m_state = S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!enable || m_pos == m_div - 1) m_enter_load(m_pend);
                    else m_pos = (m_pos + 1) % m_div;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_state = enable ? S_RUN : S_IDLE;
                end
            endcase
            m_ready = (m_state == S_IDLE) || (m_state == S_RUN);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("div_num", 32'(div_num), 32'(m_div));
            chk("div_reset", 32'(div_reset), 32'(m_state == S_IDLE || m_state == S_LOAD));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_state == S_DRAIN || m_state == S_LOAD));
            chk("period_tick", 32'(period_tick),
                32'((m_state == S_RUN || m_state == S_DRAIN) && m_pos == m_div - 1));
`ifdef CLK_DIV_CTRL_STATS_EN
            chk("reconfig_count", 32'(reconfig_count), 32'(m_stats));
`endif
        end
    end

    // Cycles until the next period_tick, bounded.
    task automatic next_tick(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!period_tick && gap < 64);
        if (!period_tick) chk("tick_timeout", 32'(0), 32'(1));
    endtask

    // Wait until the divider is running again, bounded.
    task automatic wait_run();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || div_reset) && n < 100);
        if (busy || div_reset) chk("run_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_cfg(input int v);
        cfg_valid = 1'b1;
        cfg_div   = W'(v);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int gap;
        #1 reset = 1'b1;
        @(negedge clk);
        checking = 1'b1;
        chk("rst_div_num", 32'(div_num), 32'(4));
        chk("rst_div_reset", 32'(div_reset), 32'(1));
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(cfg_ready), 32'(1));

        // Enable with no cfg: LOAD for two cycles, then RUN with period 4.
        enable = 1'b1;
        @(negedge clk);
        chk("load1_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("load2_div_reset", 32'(div_reset), 32'(1));
        @(negedge clk);
        chk("run_div_reset", 32'(div_reset), 32'(0));
        next_tick(gap); chk("first_tick_gap", 32'(gap), 32'(3));
        next_tick(gap); chk("period4_gap", 32'(gap), 32'(4));

        // Ratio 6 offered at cnt=1: drain to the boundary, load, then period 6.
        @(negedge clk);
        @(negedge clk);
        send_cfg(6);
        chk("drain_busy", 32'(busy), 32'(1));
        next_tick(gap); chk("drain_boundary_gap", 32'(gap), 32'(1));
        chk("drain_div_num", 32'(div_num), 32'(4));
        next_tick(gap); chk("load_then_run_gap", 32'(gap), 32'(8));
        chk("new_div_num", 32'(div_num), 32'(6));
        next_tick(gap); chk("period6_gap", 32'(gap), 32'(6));

        // Invalid ratio: err pulse, nothing else changes.
        send_cfg(1);
        chk("bad_err", 32'(cfg_err), 32'(1));
        chk("bad_div_num", 32'(div_num), 32'(6));
        chk("bad_busy", 32'(busy), 32'(0));
        @(negedge clk);
        chk("bad_err_pulse", 32'(cfg_err), 32'(0));

        // Enable drop in DRAIN: immediate LOAD of 8, then IDLE.
        send_cfg(8);
        chk("drain8_busy", 32'(busy), 32'(1));
        enable = 1'b0;
        @(negedge clk);
        chk("abort_div_num", 32'(div_num), 32'(8));
        chk("abort_div_reset", 32'(div_reset), 32'(1));
        @(negedge clk);
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'(0));
        chk("abort_idle_ready", 32'(cfg_ready), 32'(1));
        chk("abort_idle_div_num", 32'(div_num), 32'(8));

        // Reset in the second LOAD cycle: immediate return to reset values.
        send_cfg(9);
        chk("idle_load_div_num", 32'(div_num), 32'(9));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_div_num", 32'(div_num), 32'(4));
        chk("async_div_reset", 32'(div_reset), 32'(1));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_ready", 32'(cfg_ready), 32'(0));
`ifdef CLK_DIV_CTRL_STATS_EN
        chk("async_stats", 32'(reconfig_count), 32'(0));
`endif
        @(negedge clk);
        reset = 1'b0;

        // Ratios 5, 5, 7: the repeated ratio still sequences but is not counted.
        enable = 1'b1;
        wait_run();
        send_cfg(5); wait_run();
        send_cfg(5); wait_run();
        send_cfg(7); wait_run();
        chk("seq_div_num", 32'(div_num), 32'(7));
`ifdef CLK_DIV_CTRL_STATS_EN
        chk("stats_557", 32'(reconfig_count), 32'(2));
`endif

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            enable    = ($urandom_range(0, 19) != 0);
            cfg_valid = ($urandom_range(0, 6) == 0);
            cfg_div   = W'($urandom_range(0, 9));
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
